// File: rtl/nts_timestamp_pkg.sv
// Shared types and constants for the nts_timestamp arbiter slice.
package nts_timestamp_pkg;

  localparam int unsigned TS_W              = 64;
  localparam int unsigned VER_W             = 3;
  localparam int unsigned POLL_W            = 8;
  localparam int unsigned BLOCK_W           = 3;
  localparam int unsigned DATA_W            = 64;
  localparam int unsigned NTP_HEADER_BLOCKS = 6;
  localparam int unsigned BEAT_CNT_W        = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_RECORD   = 3'd2,
    ST_TRANSMIT = 3'd3,
    ST_WAIT_TX  = 3'd4,
    ST_STREAM   = 3'd5,
    ST_DONE     = 3'd6
  } arb_state_t;

  // Per-engine request payload handed to nts_timestamp on transmit
  typedef struct packed {
    logic [TS_W-1:0]   origin;
    logic [VER_W-1:0]  version;
    logic [POLL_W-1:0] poll;
  } parser_fields_t;

  // Beat counter increment that sticks at all-ones
  function automatic logic [BEAT_CNT_W-1:0] beat_inc(input logic [BEAT_CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + BEAT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/nts_rr_arbiter.sv
// Round-robin picker: first request above the pointer, wrapping. Purely combinational.
module nts_rr_arbiter
  import nts_timestamp_pkg::*;
#(
  parameter int unsigned ENGINES = 4,
  parameter int unsigned IDX_W   = $clog2(ENGINES)
) (
  input  logic [ENGINES-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [ENGINES-1:0] grant_c,
  output logic [IDX_W-1:0]   grant_idx_c,
  output logic               any_c
);

  localparam int unsigned CW = IDX_W + 1;

  logic [CW-1:0] cand;
  logic          found;

  // Scan ptr+1 .. ptr+ENGINES modulo ENGINES, keep the first hit
  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    cand        = '0;
    found       = 1'b0;
    for (int unsigned k = 1; k <= ENGINES; k++) begin
      cand = CW'(ptr) + CW'(k);
      if (cand >= CW'(ENGINES)) begin
        cand = cand - CW'(ENGINES);
      end
      if (!found && req[IDX_W'(cand)]) begin
        found                    = 1'b1;
        grant_c[IDX_W'(cand)]    = 1'b1;
        grant_idx_c              = IDX_W'(cand);
      end
    end
    any_c = found;
  end

endmodule

// File: rtl/nts_timestamp_arbiter.sv
// Shares one nts_timestamp among ENGINES parser engines: round-robin grant,
// clear/record/transmit strobe sequencing, header stream routing and ack.
// Optional WAIT_TX watchdog: define NTS_TS_ARB_TIMEOUT_EN.
module nts_timestamp_arbiter
  import nts_timestamp_pkg::*;
#(
  parameter int unsigned ENGINES   = 4,
  parameter int unsigned TX_BLOCKS = NTP_HEADER_BLOCKS,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                      i_clk,
  input  logic                      i_areset_n,
  input  logic [ENGINES-1:0]        i_req,
  input  logic [TS_W*ENGINES-1:0]   i_origin_timestamp,
  input  logic [VER_W*ENGINES-1:0]  i_version_number,
  input  logic [POLL_W*ENGINES-1:0] i_poll,
  output logic [ENGINES-1:0]        o_ack,
  output logic                      o_err,
  output logic                      o_busy,
  output logic                      o_parser_clear,
  output logic                      o_parser_record_receive_timestamp,
  output logic                      o_parser_transmit,
  output logic [TS_W-1:0]           o_parser_origin_timestamp,
  output logic [VER_W-1:0]          o_parser_version_number,
  output logic [POLL_W-1:0]         o_parser_poll,
  input  logic                      i_tx_wr_en,
  input  logic [BLOCK_W-1:0]        i_tx_ntp_header_block,
  input  logic [DATA_W-1:0]         i_tx_ntp_header_data,
  output logic [ENGINES-1:0]        o_tx_wr_en,
  output logic [BLOCK_W-1:0]        o_tx_ntp_header_block,
  output logic [DATA_W-1:0]         o_tx_ntp_header_data
);

  localparam int unsigned IDX_W = $clog2(ENGINES);

  arb_state_t              state;
  logic [IDX_W-1:0]        ptr_q;
  logic [IDX_W-1:0]        grant_idx_q;
  logic [ENGINES-1:0]      grant_oh_q;
  logic [BEAT_CNT_W-1:0]   beat_cnt;
  parser_fields_t          fields_q;
  parser_fields_t          eng_fields [ENGINES];

  logic [ENGINES-1:0]      arb_grant_c;
  logic [IDX_W-1:0]        arb_idx_c;
  logic                    arb_any_c;

`ifdef NTS_TS_ARB_TIMEOUT_EN
  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [WAIT_W-1:0]       wait_cnt;
`else
  // Watchdog not built: TIMEOUT only matters when it is
  if (TIMEOUT == 0) begin : g_no_timeout
  end
`endif

  // Unpack the flat per-engine buses into payload structs
  for (genvar e = 0; e < ENGINES; e++) begin : g_fields
    assign eng_fields[e] = '{origin:  i_origin_timestamp[TS_W*e +: TS_W],
                             version: i_version_number[VER_W*e +: VER_W],
                             poll:    i_poll[POLL_W*e +: POLL_W]};
  end

  nts_rr_arbiter #(
    .ENGINES (ENGINES),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req         (i_req),
    .ptr         (ptr_q),
    .grant_c     (arb_grant_c),
    .grant_idx_c (arb_idx_c),
    .any_c       (arb_any_c)
  );

  // Header stream reaches only the granted engine, and only while a stream is expected
  assign o_tx_wr_en = (i_tx_wr_en && (state == ST_WAIT_TX || state == ST_STREAM)) ? grant_oh_q : '0;
  assign o_tx_ntp_header_block = i_tx_ntp_header_block;
  assign o_tx_ntp_header_data  = i_tx_ntp_header_data;

  assign o_parser_origin_timestamp = fields_q.origin;
  assign o_parser_version_number   = fields_q.version;
  assign o_parser_poll             = fields_q.poll;

  // Transaction sequencer with registered strobes, ack and busy
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state                             <= ST_IDLE;
      ptr_q                             <= IDX_W'(ENGINES - 1);
      grant_idx_q                       <= '0;
      grant_oh_q                        <= '0;
      beat_cnt                          <= '0;
      fields_q                          <= '0;
      o_ack                             <= '0;
      o_err                             <= 1'b0;
      o_busy                            <= 1'b0;
      o_parser_clear                    <= 1'b0;
      o_parser_record_receive_timestamp <= 1'b0;
      o_parser_transmit                 <= 1'b0;
`ifdef NTS_TS_ARB_TIMEOUT_EN
      wait_cnt                          <= '0;
`endif
    end else begin
      o_parser_clear                    <= 1'b0;
      o_parser_record_receive_timestamp <= 1'b0;
      o_parser_transmit                 <= 1'b0;
      o_ack                             <= '0;
      o_err                             <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_any_c) begin
            grant_idx_q    <= arb_idx_c;
            grant_oh_q     <= arb_grant_c;
            fields_q       <= eng_fields[arb_idx_c];
            beat_cnt       <= '0;
            o_parser_clear <= 1'b1;
            o_busy         <= 1'b1;
            state          <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          o_parser_record_receive_timestamp <= 1'b1;
          state                             <= ST_RECORD;
        end
        ST_RECORD: begin
          o_parser_transmit <= 1'b1;
          state             <= ST_TRANSMIT;
`ifdef NTS_TS_ARB_TIMEOUT_EN
          wait_cnt          <= '0;
`endif
        end
        ST_TRANSMIT: begin
          state <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          if (i_tx_wr_en) begin
            beat_cnt <= BEAT_CNT_W'(1);
            state    <= ST_STREAM;
          end
`ifdef NTS_TS_ARB_TIMEOUT_EN
          else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
            beat_cnt <= '0;
            o_ack    <= grant_oh_q;
            o_err    <= 1'b1;
            state    <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
`endif
        end
        ST_STREAM: begin
          if (i_tx_wr_en) begin
            beat_cnt <= beat_inc(beat_cnt);
          end else begin
            o_ack <= grant_oh_q;
            o_err <= (beat_cnt != BEAT_CNT_W'(TX_BLOCKS));
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          ptr_q  <= grant_idx_q;
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nts_timestamp_arbiter.sv
// Scoreboard bench for nts_timestamp_arbiter with a behavioural round-robin model.
module tb_nts_timestamp_arbiter;

  localparam int unsigned E   = 4;
  localparam int unsigned TXB = 6;
  localparam int unsigned TO  = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [E-1:0]      i_req;
  logic [64*E-1:0]   i_origin;
  logic [3*E-1:0]    i_ver;
  logic [8*E-1:0]    i_poll;
  logic [E-1:0]      o_ack;
  logic              o_err;
  logic              o_busy;
  logic              o_clear;
  logic              o_record;
  logic              o_transmit;
  logic [63:0]       o_origin;
  logic [2:0]        o_ver;
  logic [7:0]        o_poll;
  logic              i_tx_wr_en;
  logic [2:0]        i_blk;
  logic [63:0]       i_data;
  logic [E-1:0]      o_tx_wr_en;
  logic [2:0]        o_blk;
  logic [63:0]       o_data;

  logic [63:0] org [E];
  logic [2:0]  ver [E];
  logic [7:0]  pol [E];

  typedef struct { int eng; bit err; } ack_exp_t;
  typedef struct packed { logic [63:0] o; logic [2:0] v; logic [7:0] p; } fld_t;
  ack_exp_t ack_q[$];
  fld_t     fld_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int last_served = E - 1;

  always #5 clk = ~clk;

  for (genvar e = 0; e < E; e++) begin : g_pack
    assign i_origin[64*e +: 64] = org[e];
    assign i_ver[3*e +: 3]      = ver[e];
    assign i_poll[8*e +: 8]     = pol[e];
  end

  nts_timestamp_arbiter #(.ENGINES(E), .TX_BLOCKS(TXB), .TIMEOUT(TO)) dut (
    .i_clk                             (clk),
    .i_areset_n                        (rst_n),
    .i_req                             (i_req),
    .i_origin_timestamp                (i_origin),
    .i_version_number                  (i_ver),
    .i_poll                            (i_poll),
    .o_ack                             (o_ack),
    .o_err                             (o_err),
    .o_busy                            (o_busy),
    .o_parser_clear                    (o_clear),
    .o_parser_record_receive_timestamp (o_record),
    .o_parser_transmit                 (o_transmit),
    .o_parser_origin_timestamp         (o_origin),
    .o_parser_version_number           (o_ver),
    .o_parser_poll                     (o_poll),
    .i_tx_wr_en                        (i_tx_wr_en),
    .i_tx_ntp_header_block             (i_blk),
    .i_tx_ntp_header_data              (i_data),
    .o_tx_wr_en                        (o_tx_wr_en),
    .o_tx_ntp_header_block             (o_blk),
    .o_tx_ntp_header_data              (o_data)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round robin as stated: first requester strictly after the last one served
  function automatic int pick(input logic [E-1:0] r);
    for (int k = 1; k <= E; k++) begin
      int e;
      e = (last_served + k) % E;
      if (r[e]) return e;
    end
    return -1;
  endfunction

  function automatic logic [E-1:0] onehot(input int e);
    logic [E-1:0] v;
    v = '0;
    v[e] = 1'b1;
    return v;
  endfunction

  task automatic randomize_fields();
    for (int e = 0; e < E; e++) begin
      org[e] = {$urandom, $urandom};
      ver[e] = 3'($urandom);
      pol[e] = 8'($urandom);
    end
  endtask

  function automatic logic [127:0] quiet_outputs();
    return {o_ack, o_err, o_busy, o_clear, o_record, o_transmit, o_origin, o_ver, o_poll, o_tx_wr_en};
  endfunction

  // Monitor: pops expectations whenever the DUT presents transmit or ack
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_transmit) begin
        if (fld_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL transmit_unexpected: got transmit expected none at %0t", $time);
        end else begin
          fld_t f;
          f = fld_q.pop_front();
          check("transmit_fields", {o_origin, o_ver, o_poll}, f);
        end
      end
      if (o_ack != '0) begin
        if (ack_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL ack_unexpected: got ack %b expected none at %0t", o_ack, $time);
        end else begin
          ack_exp_t a;
          a = ack_q.pop_front();
          check("ack_engine", o_ack, onehot(a.eng));
          check("ack_err", o_err, a.err);
        end
      end else if (o_err) begin
        vectors++; miscompares++;
        $display("FAIL err_without_ack: got err=1 expected 0 at %0t", $time);
      end
      if (o_tx_wr_en != '0) check("tx_onehot", $onehot(o_tx_wr_en), 1);
    end
  end

  // Raise a request set and check the clear/record/transmit sequence
  task automatic start_txn(input logic [E-1:0] req_v, input bit exp_err, input int exp_wait, output int w);
    int waited;
    w = pick(req_v);
    fld_q.push_back({org[w], ver[w], pol[w]});
    ack_q.push_back('{eng: w, err: exp_err});
    last_served = w;
    i_req = req_v;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!o_clear && waited < 4);
    check("clear_latency", waited, exp_wait);
    check("strobe_clear", {o_clear, o_record, o_transmit}, 3'b100);
    @(negedge clk);
    check("strobe_record", {o_clear, o_record, o_transmit}, 3'b010);
    @(negedge clk);
    check("strobe_transmit", {o_clear, o_record, o_transmit}, 3'b001);
    check("busy_active", o_busy, 1'b1);
  endtask

  // Full transaction; abort_beat>0 pulls reset after that many beats
  task automatic run_txn(input logic [E-1:0] req_v, input int nbeats, input int exp_wait,
                         input bit drop, input int abort_beat);
    int w;
    int waited;
    start_txn(req_v, (nbeats != TXB), exp_wait, w);
    randomize_fields();
    if (drop) i_req[w] = 1'b0;
    repeat ($urandom_range(1, 4)) @(negedge clk);
    for (int b = 0; b < nbeats; b++) begin
      if (b > 0) @(negedge clk);
      i_tx_wr_en = 1'b1;
      i_blk      = 3'(b);
      i_data     = {$urandom, $urandom};
      #1;
      check("tx_route", {o_tx_wr_en, o_blk, o_data}, {onehot(w), i_blk, i_data});
      if (abort_beat != 0 && b + 1 == abort_beat) begin
        rst_n = 1'b0;
        #1;
        check("abort_outputs", quiet_outputs(), '0);
        void'(ack_q.pop_back());
        last_served = E - 1;
        i_tx_wr_en  = 1'b0;
        i_req       = '0;
        repeat (2) @(negedge clk);
        check("abort_hold", quiet_outputs(), '0);
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
    end
    @(negedge clk);
    i_tx_wr_en = 1'b0;
    i_blk      = '0;
    waited = 0;
    while (o_ack == '0 && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    check("ack_latency", waited, 1);
    if (o_ack == '0 && ack_q.size() != 0) void'(ack_q.pop_back());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [E-1:0] cur;
    int nb;
    int w;
    int waited;
    rst_n      = 1'b0;
    i_req      = '0;
    i_tx_wr_en = 1'b0;
    i_blk      = '0;
    i_data     = '0;
    for (int e = 0; e < E; e++) begin
      org[e] = '0; ver[e] = '0; pol[e] = '0;
    end
    repeat (3) @(negedge clk);
    check("reset_state", quiet_outputs(), '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", quiet_outputs(), '0);

    // Single engine 0 with the reference origin
    randomize_fields();
    org[0] = 64'hffffdddd00000000;
    run_txn(4'b0001, TXB, 1, 1'b0, 0);

    // Beats outside a stream are dropped: DONE, then IDLE
    i_req      = '0;
    i_tx_wr_en = 1'b1;
    #1;
    check("done_beat_ignored", o_tx_wr_en, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_beat_ignored", {o_tx_wr_en, o_busy}, '0);
    end
    i_tx_wr_en = 1'b0;
    @(negedge clk);

    // Short stream flags error, following one is clean
    run_txn(4'b0010, 5, 1, 1'b0, 0);
    run_txn(4'b0010, TXB, 2, 1'b0, 0);
    run_txn(4'b1000, 7, 2, 1'b1, 0);

    // Reset during the third beat, then a fresh round from engine 0
    run_txn(4'b0100, TXB, 2, 1'b0, 3);
    for (int i = 0; i < 5; i++) run_txn(4'b1111, TXB, (i == 0) ? 1 : 2, 1'b0, 0);

    // Random request mixes and stream lengths
    cur = 4'b1111;
    for (int i = 0; i < 30; i++) begin
      cur = (cur & ~onehot(last_served)) | E'($urandom);
      if (cur == '0) cur = onehot($urandom_range(0, E - 1));
      case ($urandom_range(0, 9))
        7:       nb = 5;
        8:       nb = 7;
        9:       nb = $urandom_range(1, 17);
        default: nb = TXB;
      endcase
      run_txn(cur, nb, 2, 1'($urandom_range(0, 3) == 0), 0);
    end

    // Silent timestamp block
    randomize_fields();
`ifdef NTS_TS_ARB_TIMEOUT_EN
    start_txn(4'b0101, 1'b1, 2, w);
    waited = 0;
    while (o_ack == '0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("timeout_latency", waited, TO + 1);
`else
    start_txn(4'b0101, 1'b0, 2, w);
    repeat (100) @(negedge clk);
    check("wait_forever_busy", o_busy, 1'b1);
    rst_n = 1'b0;
    void'(ack_q.pop_back());
    last_served = E - 1;
    i_req = '0;
    @(negedge clk);
    rst_n = 1'b1;
`endif
    i_req = '0;
    repeat (4) @(negedge clk);
    check("ack_queue_drained", ack_q.size(), 0);
    check("field_queue_drained", fld_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
